// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_t;

    // Width never drops below one bit so parameters of 1 still give a legal vector.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return clog2_min1(m);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the lock sequencer and its PLL / reset-tree environment.
interface pll_lock_sequencer_if #(
    parameter int unsigned RETRY_W = 2
);
    logic               pll_locked;
    logic               soft_req;
    logic               clr_status;
    logic               pll_rst;
    logic               sys_rst_n;
    logic               ready;
    logic               fault;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_cnt;

    modport master (
        input  pll_locked, soft_req, clr_status,
        output pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt
    );

    modport slave (
        output pll_locked, soft_req, clr_status,
        input  pll_rst, sys_rst_n, ready, fault, lock_lost, retry_cnt
    );
endinterface

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/pll_lock_sequencer.sv
// Resets the PLL, waits for a stable lock with timeout/retry, then releases the core reset
// and re-sequences on filtered lock loss. Runs entirely on the reference clock.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 100,
    parameter int unsigned LOCK_STABLE_CYCLES  = 5000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned LOSS_FILTER         = 4
) (
    input  logic                 refclk,
    input  logic                 rst_n,
    pll_lock_sequencer_if.master bus
);
    localparam int unsigned CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int unsigned FW = clog2_min1(LOSS_FILTER + 1);
    localparam int unsigned RW = clog2_min1(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST   = FW'(LOSS_FILTER - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    logic          w_locked_s;
    seq_state_t    r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [FW-1:0] r_filt, w_filt_next;
    logic [RW-1:0] r_retry, w_retry_next, w_retry_inc;
    logic          r_lock_lost, w_lock_lost_next, w_set_lost, w_restart;
    logic          r_pll_rst, r_sys_rst_n, r_ready, r_fault;

    sync2 u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (bus.pll_locked),
        .o_q     (w_locked_s)
    );

    always_comb begin
        w_state_next = r_state;
        w_retry_next = r_retry;
        w_filt_next  = '0;
        w_set_lost   = 1'b0;
        w_restart    = 1'b0;
        w_retry_inc  = (r_retry == RETRY_MAX) ? r_retry : r_retry + RW'(1);

        case (r_state)
            PLL_RST: begin
                if (r_cnt == RST_LAST) w_state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_next = STABLE;
                end else if (r_cnt == TMO_LAST) begin
                    w_retry_next = w_retry_inc;
                    w_state_next = (w_retry_inc == RETRY_MAX) ? FAULT : PLL_RST;
                end
            end
            STABLE: begin
                if (!w_locked_s) begin
                    w_state_next = WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_next = RUN;
                    w_retry_next = '0;
                end
            end
            RUN: begin
                if (w_locked_s) begin
                    w_filt_next = '0;
                end else if (r_filt == FILT_LAST) begin
                    w_set_lost   = 1'b1;
                    w_state_next = PLL_RST;
                end else begin
                    w_filt_next = r_filt + FW'(1);
                end
            end
            FAULT: ;
            default: w_state_next = PLL_RST;
        endcase

        // soft_req overrides any same-cycle decision and forces a fresh pulse count.
        if (bus.soft_req) begin
            w_state_next = PLL_RST;
            w_retry_next = '0;
            w_set_lost   = 1'b0;
            w_filt_next  = '0;
            w_restart    = 1'b1;
        end

        if (w_restart || (w_state_next != r_state))
            w_cnt_next = '0;
        else if ((r_state == PLL_RST) || (r_state == WAIT_LOCK) || (r_state == STABLE))
            w_cnt_next = r_cnt + CW'(1);
        else
            w_cnt_next = r_cnt;

        if (w_set_lost)
            w_lock_lost_next = 1'b1;
        else if (bus.clr_status)
            w_lock_lost_next = 1'b0;
        else
            w_lock_lost_next = r_lock_lost;
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_filt      <= '0;
            r_retry     <= '0;
            r_lock_lost <= 1'b0;
            r_pll_rst   <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_filt      <= w_filt_next;
            r_retry     <= w_retry_next;
            r_lock_lost <= w_lock_lost_next;
            r_pll_rst   <= (w_state_next == PLL_RST) || (w_state_next == FAULT);
            r_sys_rst_n <= (w_state_next == RUN);
            r_ready     <= (w_state_next == RUN);
            r_fault     <= (w_state_next == FAULT);
        end
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.sys_rst_n = r_sys_rst_n;
    assign bus.ready     = r_ready;
    assign bus.fault     = r_fault;
    assign bus.lock_lost = r_lock_lost;
    assign bus.retry_cnt = r_retry;
endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences the reset and lock of the core's PLL, which takes a 50 MHz reference and produces 106.744 MHz and 53.372 MHz outputs.
- Pulses the PLL reset and waits for the PLL to lock, with a timeout and bounded retries.
- Requires lock to stay stable before releasing the system reset; watches for lock loss afterwards and re-sequences.
- Runs on the reference clock, because the PLL outputs are not trustworthy until lock. Sits between the board clock/reset and the PLL wrapper plus the core reset tree.

Parameters:
RST_PULSE_CYCLES, 100, refclk cycles that pll_rst is held high per attempt (2 us).
LOCK_STABLE_CYCLES, 5000, consecutive synced-locked cycles required before release (100 us).
LOCK_TIMEOUT_CYCLES, 500000, cycles in WAIT_LOCK before the attempt fails (10 ms).
MAX_RETRIES, 3, failed attempts allowed before FAULT.
LOSS_FILTER, 4, consecutive synced-unlocked cycles in RUN that count as lock loss.

Ports:
refclk  in  1  50 MHz reference clock; sole clock of the block.
rst_n  in  1  asynchronous, active-low reset.
pll_locked  in  1  PLL locked output; asynchronous to refclk.
soft_req  in  1  single-cycle pulse requesting a full re-lock (e.g. after a video-mode change).
clr_status  in  1  single-cycle pulse that clears lock_lost.
pll_rst  out  1  active-high reset driven to the PLL.
sys_rst_n  out  1  active-low core reset request, refclk domain. Consumers resynchronise it per clock.
ready  out  1  high only in RUN.
fault  out  1  high only in FAULT.
lock_lost  out  1  sticky flag: lock was lost while in RUN.
retry_cnt  out  $clog2(MAX_RETRIES+1)  failed attempts since the last success or soft_req.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = PLL_RST, cycle counter = 0, retry_cnt = 0, filter counter = 0, sync flops = 0.
  - Outputs: pll_rst=1, sys_rst_n=0, ready=0, fault=0, lock_lost=0.
- pll_locked passes through a 2-flop synchroniser giving locked_s, so there are 2 cycles of latency. All decisions use locked_s only.
- All outputs are registered and decoded from the current state. One cycle after a transition, outputs match the new state.
- One shared cycle counter, width $clog2 of the largest cycle parameter. It is cleared on every state entry.
- States and transitions:
  - PLL_RST: pll_rst=1, sys_rst_n=0. When counter reaches RST_PULSE_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0, sys_rst_n=0.
    - locked_s=1: go to STABLE.
    - Counter reaches LOCK_TIMEOUT_CYCLES-1: retry_cnt+1. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to PLL_RST.
  - STABLE: pll_rst=0, sys_rst_n=0.
    - locked_s=0: go to WAIT_LOCK; the timeout restarts from 0.
    - Counter reaches LOCK_STABLE_CYCLES-1 with locked_s=1: go to RUN and clear retry_cnt.
  - RUN: pll_rst=0, sys_rst_n=1, ready=1.
    - Filter counter increments while locked_s=0 and clears when locked_s=1.
    - Filter counter reaches LOSS_FILTER: set lock_lost, go to PLL_RST. sys_rst_n falls on the next edge.
    - A glitch shorter than LOSS_FILTER cycles causes no action.
  - FAULT: pll_rst=1, sys_rst_n=0, fault=1. Leaves only on soft_req or rst_n.
- soft_req, in any state:
  - Go to PLL_RST, clear retry_cnt, clear fault.
  - Takes priority over every same-cycle event: timeout, stable completion, lock loss.
  - soft_req while already in PLL_RST restarts the pulse count.
- clr_status clears lock_lost. If a lock-loss set occurs in the same cycle, the set wins.
- retry_cnt saturates at MAX_RETRIES and never wraps.
- pll_locked toggling during PLL_RST is ignored.
- Parameters of 1 must work: a single-cycle pulse/window, and a filter of 1 meaning immediate loss.

Decomposition:
- Package pll_seq_pkg holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT);
  - a function computing the counter width from the parameters.
- One natural sub-module: sync2, the generic 2-flop synchroniser for pll_locked, reusable across the core's CDC points.

Test Plan (bench params: RST_PULSE=4, STABLE=8, TIMEOUT=32, MAX_RETRIES=2, LOSS_FILTER=3):
1. Release rst_n with pll_locked=1 tied -> pll_rst high for exactly 4 cycles, then low. sys_rst_n and ready rise 8 cycles after locked_s first reads 1 in STABLE, plus sync latency. retry_cnt=0.
2. Hold pll_locked=0 -> PLL_RST→WAIT_LOCK twice, 32-cycle timeouts, retry_cnt 1 then 2. fault=1 and pll_rst=1 remain held; a later pll_locked=1 has no effect. Pulse soft_req -> fault=0, retry_cnt=0, new 4-cycle pll_rst pulse.
3. In RUN, drop pll_locked for 2 cycles -> no change. Drop it for 3 cycles -> lock_lost=1, sys_rst_n=0, ready=0, pll_rst pulse; relock returns to RUN with lock_lost still 1. clr_status -> lock_lost=0.
4. In STABLE at count 5, drop pll_locked for 1 cycle -> return to WAIT_LOCK; release occurs a full 8 stable cycles after relock.
5. soft_req in the same cycle as the WAIT_LOCK timeout at retry_cnt=1 -> PLL_RST, retry_cnt=0, fault stays 0. clr_status in the same cycle as a lock-loss set -> lock_lost=1.
6. Assert rst_n low mid-RUN, asynchronously between edges -> pll_rst=1, sys_rst_n=0, ready=0 immediately without a clock edge. After release, the full sequence repeats.
